// File: rtl/gol_ctrl_fsm_p.sv
// Game of Life sequencing controller. It runs the board load (INPUT), the
// generation update (IREAD) and the commit (WRITEOUT) passes. It counts
// generations toward a win, and supports pause, single-step and new-game.
// Every output is registered and decoded from the next state, so a state
// change and its flags appear on the same clka edge.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | waiting for a load, run, pause or new-game request
//  WIN1      | win reached (sticky until new_game or reset)
//  INPUT     | board load pass, CELLS cycles
//  IREAD     | generation update pass, CELLS cycles
//  WRITEOUT  | single-cycle commit; bumps gen_count after IREAD
//  WAIT      | paused; a step pulse runs exactly one generation
//  LOSE1     | loss reached (sticky until new_game or reset)
//  RESTART   | soft restart; gen_count cleared
module gol_ctrl_fsm_p #(
  parameter int CELLS    = 16,
  parameter int CNT_W    = 9,
  parameter int WIN_GENS = 50,
  parameter int GEN_W    = 9
) (
  input  logic             clka,
  input  logic             reset,
  input  logic             inp,
  input  logic             run,
  input  logic             wai,
  input  logic             step,
  input  logic             new_game,
  input  logic             lose_sig,
  output logic             load_data,
  output logic             read_data,
  output logic             write_data,
  output logic             writeout,
  output logic             restart,
  output logic             win,
  output logic             lose,
  output logic             busy,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] count,
  output logic [GEN_W-1:0] gen_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    WIN1     = 3'b001,
    INPUT    = 3'b010,
    IREAD    = 3'b011,
    WRITEOUT = 3'b100,
    WAIT     = 3'b101,
    LOSE1    = 3'b110,
    RESTART  = 3'b111
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CELLS - 1);
  localparam logic [GEN_W-1:0] WIN_CNT  = GEN_W'(WIN_GENS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [GEN_W-1:0] gen_count_q, gen_count_d;
  logic             load_data_q, load_data_d;
  logic             read_data_q, read_data_d;
  logic             write_data_q, write_data_d;
  logic             writeout_q, writeout_d;
  logic             restart_q, restart_d;
  logic             win_q, win_d;
  logic             lose_q, lose_d;
  logic             busy_q, busy_d;

  // Next-state, pass counter and generation counter.
  always_comb begin
    state_d     = state_q;
    count_d     = '0;
    gen_count_d = gen_count_q;
    case (state_q)
      RESTART: state_d = inp ? INPUT : IDLE;
      IDLE: begin
        if (new_game)      state_d = RESTART;
        else if (inp)      state_d = INPUT;
        else if (lose_sig) state_d = LOSE1;
        else if (wai)      state_d = WAIT;
        else if (run)      state_d = IREAD;
        else               state_d = IDLE;
      end
      INPUT, IREAD: begin
        // A pass is never aborted; the only way out is reaching its last cycle.
        if (count_q == LAST_CNT) begin
          state_d = WRITEOUT;
          if (state_q == IREAD && gen_count_q < WIN_CNT) begin
            gen_count_d = gen_count_q + GEN_W'(1);
          end
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      WRITEOUT: begin
        // gen_count_q already holds the value updated on entry to WRITEOUT.
        if (lose_sig)                    state_d = LOSE1;
        else if (gen_count_q == WIN_CNT) state_d = WIN1;
        else                             state_d = IDLE;
      end
      WAIT: begin
        if (new_game)      state_d = RESTART;
        else if (lose_sig) state_d = LOSE1;
        else if (step)     state_d = IREAD;
        else if (!wai)     state_d = IDLE;
        else               state_d = WAIT;
      end
      WIN1, LOSE1: begin
        if (new_game) state_d = RESTART;
      end
      default: state_d = RESTART;
    endcase
    if (state_d == RESTART) gen_count_d = '0;
  end

  // Output flags decoded from the next state so they register alongside it.
  always_comb begin
    load_data_d  = (state_d == INPUT);
    read_data_d  = (state_d == IREAD);
    write_data_d = (state_d == INPUT) || (state_d == IREAD);
    writeout_d   = (state_d == WRITEOUT);
    restart_d    = (state_d == RESTART);
    win_d        = (state_d == WIN1);
    lose_d       = (state_d == LOSE1);
    busy_d       = (state_d == INPUT) || (state_d == IREAD) || (state_d == WRITEOUT);
  end

  // State, counters and output flags; reset parks the FSM in RESTART.
  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      state_q      <= RESTART;
      count_q      <= '0;
      gen_count_q  <= '0;
      load_data_q  <= 1'b0;
      read_data_q  <= 1'b0;
      write_data_q <= 1'b0;
      writeout_q   <= 1'b0;
      restart_q    <= 1'b1;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      gen_count_q  <= gen_count_d;
      load_data_q  <= load_data_d;
      read_data_q  <= read_data_d;
      write_data_q <= write_data_d;
      writeout_q   <= writeout_d;
      restart_q    <= restart_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
      busy_q       <= busy_d;
    end
  end

  assign load_data  = load_data_q;
  assign read_data  = read_data_q;
  assign write_data = write_data_q;
  assign writeout   = writeout_q;
  assign restart    = restart_q;
  assign win        = win_q;
  assign lose       = lose_q;
  assign busy       = busy_q;
  assign state      = state_q;
  assign count      = count_q;
  assign gen_count  = gen_count_q;

endmodule
